roi_sched: RTL
==============

# roi_sched

Per-frame ROI window scheduler for the `roi` crop block. It holds a table of up to DEPTH crop windows written through a handshaked config port and drives `roi`'s start/end coordinate inputs, switching windows only at frame boundaries. It monitors the same pixel stream that feeds `roi` (valid/last) and steps round-robin through the programmed entries, so one window applies per frame.

## Interface
- WIDTH, 1920, frame width in pixels; X coordinate width XW = $clog2(WIDTH)
- HEIGHT, 1080, frame height in lines; Y coordinate width YW = $clog2(HEIGHT)
- DEPTH, 4, number of window table entries; index width AW = $clog2(DEPTH)
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- wr_valid_i  in  1  config write request
- wr_ready_o  out  1  config write accepted when high together with wr_valid_i
- wr_addr_i  in  AW  table entry to write
- wr_start_x_i / wr_end_x_i  in  XW each  window X bounds, inclusive
- wr_start_y_i / wr_end_y_i  in  YW each  window Y bounds, inclusive
- count_i  in  $clog2(DEPTH+1)  entries in the rotation (1..DEPTH), sampled on start
- start_i / stop_i  in  1 each  single-cycle run/halt commands
- frame_valid_i / frame_last_i  in  1 each  taps of the pixel stream into `roi`
- roi_start_x_o, roi_end_x_o  out  XW  active window X, to `roi`
- roi_start_y_o, roi_end_y_o  out  YW  active window Y, to `roi`
- roi_en_o  out  1  active window valid; `roi` gates its output with it
- roi_idx_o  out  AW  index of the active entry
- busy_o  out  1  high in ARM and RUN
- err_o  out  1  one-cycle pulse on a rejected write

## Operation
- Table entry: four coordinates plus valid bit; all valid bits cleared by reset.
- Write check: start_x<=end_x, end_x<WIDTH, start_y<=end_y, end_y<HEIGHT. Pass: entry written, valid set. Fail: entry and valid bit unchanged, err_o pulses the next cycle.
- wr_ready_o = 0 only when state is RUN and wr_addr_i equals roi_idx_o. The active window is never modified mid-use. Otherwise it is 1.
- in_frame flag: set on frame_valid_i && !frame_last_i, cleared on frame_valid_i && frame_last_i.
- boundary = (frame_valid_i && frame_last_i) || (!in_frame && !frame_valid_i).
- States:
  - IDLE: roi_en_o=0, busy_o=0.
  - start_i with count_i in 1..DEPTH: latch count_i, go to ARM. Other count_i values: ignored.
  - ARM: on boundary, load entry 0 into the outputs, roi_idx_o=0, go to RUN.
  - RUN: on frame_valid_i && frame_last_i, idx = (idx==count-1) ? 0 : idx+1. Load that entry. roi_en_o = that entry's valid bit; an invalid entry disables output for that whole frame.
- start_i in ARM/RUN: ignored.
- stop_i: sets stop_pending. At the next boundary the state goes to IDLE, roi_en_o=0, and stop_pending clears. Stop in ARM goes to IDLE at the next boundary without loading anything.
- start_i and stop_i in the same cycle: stop wins.
- Reset mid-frame: state IDLE, table invalidated, all outputs 0 asynchronously.

## Timing
- Reset values: all outputs 0 except wr_ready_o=1; state IDLE; stop_pending=0; in_frame=0.
- All outputs are registered except wr_ready_o, which is combinational from state, roi_idx_o and wr_addr_i.
- Window switch latency is 1 cycle: outputs change on the edge after the boundary cycle, so the first pixel of the next frame sees the new window. Back-to-back frames (last followed immediately by valid) are supported.
- A write takes effect 1 cycle after the handshake. A write to the entry about to be loaded, made in the boundary cycle, is not seen; the old value loads.
- err_o is one cycle wide, 1 cycle after the rejected handshake.

## Configuration
- ROI_SCHED_CLAMP_EN defined:
  - end_x>=WIDTH is stored as WIDTH-1; end_y>=HEIGHT is stored as HEIGHT-1.
  - The write is accepted with no err_o, provided start<=clamped end.
  - start>=WIDTH or start>=HEIGHT is still rejected.
- Undefined: out-of-range values are rejected per Operation.

## Test plan
- Write entry 0 = (1320,280)-(1420,380), start_i with count_i=1, send a 1920x1080 frame -> outputs hold 1320/280/1420/380 with roi_en_o=1 from the first pixel; roi_idx_o stays 0 across three frames.
- Entries 0..2 programmed, count_i=3, four frames -> roi_idx_o sequence 0,1,2,0. Each change lands 1 cycle after frame_last_i.
- Write with end_x=1920:
  - Macro undefined: err_o pulses, entry unchanged.
  - ROI_SCHED_CLAMP_EN defined: stored end_x=1919, no err_o.
- In RUN on idx 1, write to addr 1 -> wr_ready_o=0. Write to addr 2 -> accepted; the new value appears when idx reaches 2.
- stop_i mid-frame -> window held until frame_last_i, then roi_en_o=0 and busy_o=0 next cycle. start_i and stop_i in the same cycle from IDLE -> stays IDLE.
- Assert rst mid-frame in RUN -> outputs 0 immediately. After release, start_i with all entries invalid and count_i=1 -> RUN with roi_en_o=0.

Source files
------------

// File: rtl/roi_sched.sv
// Per-frame ROI window scheduler: a table of crop windows stepped round-robin at frame boundaries.
// Optional ROI_SCHED_CLAMP_EN clamps out-of-range end coordinates on write instead of rejecting.
module roi_sched #(
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT),
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [XW-1:0] wr_start_x_i,
  input  logic [XW-1:0] wr_end_x_i,
  input  logic [YW-1:0] wr_start_y_i,
  input  logic [YW-1:0] wr_end_y_i,
  input  logic [CW-1:0] count_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          frame_valid_i,
  input  logic          frame_last_i,
  output logic [XW-1:0] roi_start_x_o,
  output logic [XW-1:0] roi_end_x_o,
  output logic [YW-1:0] roi_start_y_o,
  output logic [YW-1:0] roi_end_y_o,
  output logic          roi_en_o,
  output logic [AW-1:0] roi_idx_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam logic [XW-1:0] XMax = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(HEIGHT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          stop_pend_q, stop_pend_d;
  logic          in_frame_q, in_frame_d;
  logic [XW-1:0] sx_q, sx_d, ex_q, ex_d;
  logic [YW-1:0] sy_q, sy_d, ey_q, ey_d;
  logic          en_q, en_d, busy_q, busy_d, err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [XW-1:0] tab_sx_q [DEPTH];
  logic [XW-1:0] tab_ex_q [DEPTH];
  logic [YW-1:0] tab_sy_q [DEPTH];
  logic [YW-1:0] tab_ey_q [DEPTH];
  logic [DEPTH-1:0] tab_v_q;

  logic          wr_fire, wr_ok, boundary, eof, count_ok, load;
  logic [XW-1:0] wr_ex;
  logic [YW-1:0] wr_ey;
  logic [AW-1:0] load_idx;

  assign wr_ready_o = !((state_q == StRun) && (wr_addr_i == idx_q));
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign eof        = frame_valid_i && frame_last_i;
  assign boundary   = eof || (!in_frame_q && !frame_valid_i);
  assign count_ok   = (count_i != '0) && (count_i <= CW'(DEPTH));

  always_comb begin
    wr_ex = wr_end_x_i;
    wr_ey = wr_end_y_i;
`ifdef ROI_SCHED_CLAMP_EN
    if (wr_end_x_i > XMax) wr_ex = XMax;
    if (wr_end_y_i > YMax) wr_ey = YMax;
    wr_ok = (wr_start_x_i <= XMax) && (wr_start_y_i <= YMax) &&
            (wr_start_x_i <= wr_ex) && (wr_start_y_i <= wr_ey);
`else
    wr_ok = (wr_start_x_i <= wr_end_x_i) && (wr_end_x_i <= XMax) &&
            (wr_start_y_i <= wr_end_y_i) && (wr_end_y_i <= YMax);
`endif
    wr_ok = wr_ok && ({1'b0, wr_addr_i} < DEPTH[AW:0]);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    in_frame_d  = in_frame_q;
    en_d        = en_q;
    load        = 1'b0;
    load_idx    = idx_q;
    if (frame_valid_i) in_frame_d = !frame_last_i;
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i && count_ok) begin
          count_d = count_i;
          state_d = StArm;
        end
      end
      StArm, StRun: begin
        stop_pend_d = stop_pend_q | stop_i;
        if (stop_pend_q && boundary) begin
          state_d     = StIdle;
          en_d        = 1'b0;
          stop_pend_d = 1'b0;
        end else if (state_q == StArm && boundary) begin
          load     = 1'b1;
          load_idx = '0;
          state_d  = StRun;
        end else if (state_q == StRun && eof) begin
          load     = 1'b1;
          load_idx = (CW'(idx_q) + CW'(1) == count_q) ? '0 : idx_q + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Loads read the table as it stood before this cycle's write.
    idx_d = load ? load_idx : idx_q;
    sx_d  = load ? tab_sx_q[load_idx] : sx_q;
    ex_d  = load ? tab_ex_q[load_idx] : ex_q;
    sy_d  = load ? tab_sy_q[load_idx] : sy_q;
    ey_d  = load ? tab_ey_q[load_idx] : ey_q;
    if (load) en_d = tab_v_q[load_idx];
    busy_d = (state_d != StIdle);
    err_d  = wr_fire && !wr_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      in_frame_q  <= 1'b0;
      sx_q        <= '0;
      ex_q        <= '0;
      sy_q        <= '0;
      ey_q        <= '0;
      en_q        <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tab_v_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_sx_q[i] <= '0;
        tab_ex_q[i] <= '0;
        tab_sy_q[i] <= '0;
        tab_ey_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      in_frame_q  <= in_frame_d;
      sx_q        <= sx_d;
      ex_q        <= ex_d;
      sy_q        <= sy_d;
      ey_q        <= ey_d;
      en_q        <= en_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      if (wr_fire && wr_ok) begin
        tab_sx_q[wr_addr_i] <= wr_start_x_i;
        tab_ex_q[wr_addr_i] <= wr_ex;
        tab_sy_q[wr_addr_i] <= wr_start_y_i;
        tab_ey_q[wr_addr_i] <= wr_ey;
        tab_v_q[wr_addr_i]  <= 1'b1;
      end
    end
  end

  assign roi_start_x_o = sx_q;
  assign roi_end_x_o   = ex_q;
  assign roi_start_y_o = sy_q;
  assign roi_end_y_o   = ey_q;
  assign roi_en_o      = en_q;
  assign roi_idx_o     = idx_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule
